// File: rtl/aes_uart_ctrl.sv
// aes_uart_ctrl: byte-command sequencer between UART RX, the AES core and UART TX.
//
// state    | meaning
// IDLE     | waiting for a command byte
// KEY      | collecting 16 key bytes into the staging register
// DATA     | collecting 16 data bytes into the staging register
// START    | aes_start pulse is on the output
// WAIT     | waiting for aes_done
// TX_LOAD  | handing the next result byte to the transmitter
// TX_WAIT  | waiting for tx_done of the current result byte
// ACK      | handing ACK_BYTE to the transmitter
// ACK_WAIT | waiting for tx_done of ACK_BYTE
//
// All pulse outputs (aes_start, tx_start, err) are registered. An error is
// therefore visible the cycle after the event that caused it. This includes a
// timeout, which is detected on the TIMEOUT_CYCLES-th idle cycle.
module aes_uart_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_mode,
  output logic         aes_start,
  input  logic [127:0] aes_dout,
  input  logic         aes_done,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_done,
  output logic         busy,
  output logic         key_valid,
  output logic         err,
  output logic [1:0]   err_code
);
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    CMD_K    = 8'h4B;
  localparam logic [7:0]    CMD_E    = 8'h45;
  localparam logic [7:0]    CMD_D    = 8'h44;

  typedef enum logic [3:0] {
    S_IDLE, S_KEY, S_DATA, S_START, S_WAIT, S_TX_LOAD, S_TX_WAIT, S_ACK, S_ACK_WAIT
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [127:0]   stage_q, stage_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   din_q, din_d;
  logic           mode_q, mode_d;
  logic           key_valid_q, key_valid_d;
  logic [127:0]   out_q, out_d;
  logic           aes_start_q, aes_start_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [127:0]   stage_shift;

  assign stage_shift = {stage_q[119:0], rx_data};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      stage_q     <= '0;
      key_q       <= '0;
      din_q       <= '0;
      mode_q      <= 1'b0;
      key_valid_q <= 1'b0;
      out_q       <= '0;
      aes_start_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      stage_q     <= stage_d;
      key_q       <= key_d;
      din_q       <= din_d;
      mode_q      <= mode_d;
      key_valid_q <= key_valid_d;
      out_q       <= out_d;
      aes_start_q <= aes_start_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Next-state, datapath updates and pulse generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    stage_d     = stage_q;
    key_d       = key_q;
    din_d       = din_q;
    mode_d      = mode_q;
    key_valid_d = key_valid_q;
    out_d       = out_q;
    aes_start_d = 1'b0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_K) begin
            state_d = S_KEY;
            cnt_d   = '0;
            tmr_d   = TMR_LOAD;
          end else if ((rx_data == CMD_E || rx_data == CMD_D) && key_valid_q) begin
            state_d = S_DATA;
            mode_d  = (rx_data == CMD_D);
            cnt_d   = '0;
            tmr_d   = TMR_LOAD;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
      end
      S_KEY, S_DATA: begin
        // Timeout has priority over a byte arriving in the same cycle
        if (tmr_q == '0) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          err_d      = 1'b1;
          err_code_d = 2'd1;
        end else if (rx_valid) begin
          stage_d = stage_shift;
          cnt_d   = cnt_q + 4'd1;
          tmr_d   = TMR_LOAD;
          if (cnt_q == 4'd15) begin
            if (state_q == S_KEY) begin
              key_d       = stage_shift;
              key_valid_d = 1'b1;
              state_d     = S_ACK;
            end else begin
              din_d       = stage_shift;
              aes_start_d = 1'b1;
              state_d     = S_START;
            end
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (aes_done) begin
          out_d   = aes_dout;
          state_d = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        tx_start_d = 1'b1;
        tx_data_d  = out_q[127:120];
        state_d    = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          out_d   = {out_q[119:0], 8'h00};
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'd15) ? S_IDLE : S_TX_LOAD;
        end
      end
      S_ACK: begin
        tx_start_d = 1'b1;
        tx_data_d  = ACK_BYTE;
        state_d    = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_valid && (state_q inside {S_START, S_WAIT, S_TX_LOAD, S_TX_WAIT, S_ACK, S_ACK_WAIT})) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end
  end

  assign aes_key   = key_q;
  assign aes_din   = din_q;
  assign aes_mode  = mode_q;
  assign aes_start = aes_start_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = (state_q != S_IDLE);
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Bench for aes_uart_ctrl: command table plus hand-written corner sequences,
// with AES/TX responders and an expected-byte queue for the transmit stream.
module tb_aes_uart_ctrl;
  localparam logic [127:0] KEY1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  logic         clk, rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] aes_key, aes_din, aes_dout;
  logic         aes_mode, aes_start, aes_done;
  logic [7:0]   tx_data;
  logic         tx_start, tx_done;
  logic         busy, key_valid, err;
  logic [1:0]   err_code;

  aes_uart_ctrl #(.TIMEOUT_CYCLES(100), .ACK_BYTE(8'h06)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .aes_key(aes_key), .aes_din(aes_din), .aes_mode(aes_mode), .aes_start(aes_start),
    .aes_dout(aes_dout), .aes_done(aes_done), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .busy(busy), .key_valid(key_valid), .err(err), .err_code(err_code)
  );

  typedef struct {
    logic [7:0]   cmd;
    logic [127:0] payload;
    int           npay;
    logic         exp_err;
    logic [1:0]   exp_code;
    logic         exp_kv;
    int           exp_starts;
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, err_cnt = 0, err_cyc = 0, start_cnt = 0, tx_cnt = 0;
  int done_cyc = 0, aes_done_cyc = 0, last_rx_cyc = 0;
  int aes_lat = 4, tx_lat = 3;
  logic [1:0]   last_code = 2'd0;
  bit           aes_flag = 0, follow = 0, tx_busy = 0, bench_kv = 0;
  logic [7:0]   exp_tx[$];
  logic [127:0] exp_key = '0, exp_din = '0, bench_key = '0;
  logic         exp_mode = 1'b0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] d, input logic m);
    if (k == KEY1 && d == PT1 && !m) return CT1;
    return {d[63:0], d[127:64]} ^ k ^ {128{m}};
  endfunction

  // Pulse monitors
  always @(negedge clk) begin
    if (err) begin err_cnt++; last_code = err_code; err_cyc = cyc; end
    if (aes_start) start_cnt++;
    if (tx_start) tx_cnt++;
  end

  // AES core model
  initial begin
    logic [127:0] k, d;
    logic m;
    aes_done = 0; aes_dout = '0;
    forever begin
      @(negedge clk);
      if (aes_start) begin
        chk("aes_start_lat", cyc, last_rx_cyc + 1);
        chk("aes_key_at_start", aes_key, exp_key);
        chk("aes_din_at_start", aes_din, exp_din);
        chk("aes_mode_at_start", aes_mode, exp_mode);
        k = aes_key; d = aes_din; m = aes_mode;
        repeat (aes_lat) @(posedge clk);
        #1;
        chk("aes_inputs_hold", {aes_key ^ aes_din, 127'b0, aes_mode}, {k ^ d, 127'b0, m});
        aes_dout = fake_aes(k, d, m); aes_done = 1; aes_done_cyc = cyc; aes_flag = 1;
        @(posedge clk); #1 aes_done = 0;
      end
    end
  end

  // UART transmitter model, pops the expected-byte queue
  initial begin
    logic [7:0] b;
    tx_done = 0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (aes_flag) begin chk("tx_after_aes_lat", cyc, aes_done_cyc + 2); aes_flag = 0; end
        else if (follow) chk("tx_after_done_lat", cyc, done_cyc + 2);
        follow = 0;
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_data", tx_data, exp_tx.pop_front());
        b = tx_data; tx_busy = 1;
        repeat (tx_lat) @(posedge clk);
        #1;
        chk("tx_data_hold", tx_data, b);
        tx_done = 1; done_cyc = cyc;
        @(posedge clk); #1 tx_done = 0; tx_busy = 0;
        if (exp_tx.size() != 0) follow = 1;
        else chk("busy_after_last_tx", busy, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1; last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic send_cmd(input vec_t v);
    send_byte(v.cmd);
    for (int i = 0; i < v.npay; i++) send_byte(v.payload[127-8*i -: 8]);
  endtask

  task automatic prep(input vec_t v);
    if (v.cmd == 8'h4B && v.npay == 16) exp_tx.push_back(8'h06);
    else if ((v.cmd == 8'h45 || v.cmd == 8'h44) && bench_kv && v.npay == 16) begin
      logic [127:0] r;
      exp_key = bench_key; exp_din = v.payload; exp_mode = (v.cmd == 8'h44);
      r = fake_aes(bench_key, v.payload, exp_mode);
      for (int i = 0; i < 16; i++) exp_tx.push_back(r[127-8*i -: 8]);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_tx.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("idle_budget", n < budget, 1);
    if (n >= budget) exp_tx.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int e0, s0, t0, q0;
    e0 = err_cnt; s0 = start_cnt; t0 = tx_cnt; q0 = exp_tx.size();
    prep(v);
    q0 = exp_tx.size() - q0;
    send_cmd(v);
    if (v.cmd == 8'h4B && v.npay == 16) begin bench_kv = 1; bench_key = v.payload; end
    wait_idle(2000);
    chk({tag, "_err_pulses"}, err_cnt - e0, v.exp_err);
    if (v.exp_err) chk({tag, "_err_code"}, last_code, v.exp_code);
    chk({tag, "_aes_starts"}, start_cnt - s0, v.exp_starts);
    chk({tag, "_tx_count"}, tx_cnt - t0, q0);
    chk({tag, "_key_valid"}, key_valid, v.exp_kv);
    chk({tag, "_aes_key"}, aes_key, bench_key);
    chk({tag, "_busy"}, busy, 0);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    int e0, s0, t0, b;
    vecs[0] = '{8'h44, 128'h0, 0, 1'b1, 2'd2, 1'b0, 0};
    vecs[1] = '{8'h45, 128'h0, 0, 1'b1, 2'd2, 1'b0, 0};
    vecs[2] = '{8'h4C, 128'h0, 0, 1'b1, 2'd2, 1'b0, 0};
    vecs[3] = '{8'h4B, KEY1,   16, 1'b0, 2'd0, 1'b1, 0};
    vecs[4] = '{8'h45, PT1,    16, 1'b0, 2'd0, 1'b1, 1};
    vecs[5] = '{8'h44, CT1,    16, 1'b0, 2'd0, 1'b1, 1};
    vecs[6] = '{8'h00, 128'h0, 0, 1'b1, 2'd2, 1'b1, 0};
    vecs[7] = '{8'h4B, KEY2,   16, 1'b0, 2'd0, 1'b1, 0};
    vecs[8] = '{8'h44, PT1,    16, 1'b0, 2'd0, 1'b1, 1};
    vecs[9] = '{8'h45, {16{8'hA5}}, 16, 1'b0, 2'd0, 1'b1, 1};

    rst = 1; rx_valid = 0; rx_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key", aes_key, 0);
    chk("reset_din", aes_din, 0);
    chk("reset_ctl", {aes_mode, aes_start, tx_data, tx_start, busy, key_valid, err, err_code}, 0);
    rst = 0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Timeout after 5 data bytes, then a full command completes normally
    e0 = err_cnt;
    send_byte(8'h45);
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    b = last_rx_cyc;
    for (int n = 0; n < 300 && err_cnt == e0; n++) @(negedge clk);
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_err_code", last_code, 1);
    chk("to_err_cycle", err_cyc, b + 101);
    chk("to_busy", busy, 0);
    chk("to_key_kept", aes_key, bench_key);
    chk("to_kv_kept", key_valid, 1);
    v = '{8'h45, 128'hfedcba98_76543210_01234567_89abcdef, 16, 1'b0, 2'd0, 1'b1, 1};
    run_vec(v, "after_to");

    // A byte arriving in the very cycle the timeout fires is discarded
    e0 = err_cnt;
    send_byte(8'h44); send_byte(8'h01); send_byte(8'h02);
    b = last_rx_cyc;
    while (cyc < b + 99) begin @(posedge clk); #1; end
    send_byte(8'h4B);
    repeat (5) @(negedge clk);
    chk("tow_err_pulses", err_cnt - e0, 1);
    chk("tow_err_code", last_code, 1);
    chk("tow_err_cycle", err_cyc, b + 101);
    chk("tow_busy", busy, 0);

    // Byte injected during WAIT: code 3, result stream unaffected
    aes_lat = 30;
    v = '{8'h45, 128'h00112233_44556677_8899aabb_ccddeeff, 16, 1'b0, 2'd0, 1'b1, 1};
    e0 = err_cnt; s0 = start_cnt; t0 = tx_cnt;
    prep(v);
    send_cmd(v);
    repeat (5) @(posedge clk);
    send_byte(8'h4B);
    wait_idle(2000);
    chk("inj_err_pulses", err_cnt - e0, 1);
    chk("inj_err_code", last_code, 3);
    chk("inj_aes_starts", start_cnt - s0, 1);
    chk("inj_tx_count", tx_cnt - t0, 16);
    chk("inj_key_kept", aes_key, bench_key);
    aes_lat = 4;

    // Reset in the middle of a key load
    send_byte(8'h4B);
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i));
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_kv", key_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_key", aes_key, 0);
    rst = 0; bench_kv = 0; bench_key = '0;
    v = '{8'h44, 128'h0, 0, 1'b1, 2'd2, 1'b0, 0};
    run_vec(v, "rst_nokey");
    v = '{8'h4B, KEY1, 16, 1'b0, 2'd0, 1'b1, 0};
    run_vec(v, "rst_key");
    v = '{8'h45, PT1, 16, 1'b0, 2'd0, 1'b1, 1};
    run_vec(v, "rst_enc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
